// File: rtl/dcache_direct.sv
// dcache_direct
// Direct-mapped, write-back, write-allocate data cache between the pipeline
// MEM stage and a word-wide memory bus.
//
// Hits (read or write) complete combinationally: ok rises in the cycle the
// request is presented, and a write merges its enabled bytes at that edge.
// A miss holds ok low while the FSM writes back a dirty victim line and then
// refills the line, one word per memory handshake, in ascending word order.
//
// Optional feature: define DCACHE_STATS_EN to add hit/miss/writeback counters.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req             CPU request valid, held with its fields stable until ok
//   wreq            1 = write, 0 = read
//   addr            byte address (addr[1:0] ignored)
//   write_data      store data
//   wbyte           byte enables for writes (bit i covers bits 8i+7:8i)
//   read_data       selected word of the indexed line
//   ok              request completes this cycle
//   mem_req         memory beat request, held until mem_ok
//   mem_wreq        1 = writeback beat, 0 = refill beat
//   mem_addr        word-aligned beat address
//   mem_wdata       writeback beat data
//   mem_rdata       refill data, valid with mem_ok
//   mem_ok          one-cycle beat acknowledge
//   o_dbg_state     current FSM state (0 IDLE, 1 WB, 2 REFILL)
//   hit_cnt, miss_cnt, wb_cnt   saturating counters (DCACHE_STATS_EN only)
//
// Memory handshake: a beat is transferred on the rising edge where both
// mem_req and mem_ok are high; mem_req and all mem_* outputs stay constant
// until that edge, and mem_ok is ignored while no beat is requested.
module dcache_direct #(
  parameter int WIDTH       = 32,
  parameter int INDEX_WIDTH = 6,
  parameter int WORD_BITS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             wreq,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [3:0]       wbyte,
  output logic [WIDTH-1:0] read_data,
  output logic             ok,
  output logic             mem_req,
  output logic             mem_wreq,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ok,
  output logic [1:0]       o_dbg_state
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt,
  output logic [31:0]      wb_cnt
`endif
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << WORD_BITS;
  localparam int TAG_W = WIDTH - INDEX_WIDTH - WORD_BITS - 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WB     = 2'd1,
    S_REFILL = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Line storage; asynchronous read so hits resolve in the same cycle.
  logic [WIDTH-1:0]       r_data [0:LINES-1][0:WORDS-1];
  logic [TAG_W-1:0]       r_tag  [0:LINES-1];
  logic [LINES-1:0]       r_valid;
  logic [LINES-1:0]       r_dirty;
  logic [WORD_BITS-1:0]   r_cnt;

  // The missing line's index/tag are captured when the miss starts so the
  // line operation can finish correctly even if req drops (pipeline flush).
  logic [INDEX_WIDTH-1:0] r_miss_idx;
  logic [TAG_W-1:0]       r_miss_tag;

  logic [WORD_BITS-1:0]   w_off;
  logic [INDEX_WIDTH-1:0] w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic                   w_hit;
  logic                   w_miss;
  logic                   w_beat;
  logic                   w_last;
  logic                   w_unused;

  assign w_off = addr[WORD_BITS+1:2];
  assign w_idx = addr[WORD_BITS+INDEX_WIDTH+1:WORD_BITS+2];
  assign w_tag = addr[WIDTH-1:WORD_BITS+INDEX_WIDTH+2];
  assign w_unused = &{1'b0, addr[1:0]};

  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign ok     = req && w_hit && (r_state == S_IDLE);
  assign w_miss = req && !w_hit && (r_state == S_IDLE);
  assign w_beat = mem_ok && (r_state != S_IDLE);
  assign w_last = (r_cnt == {WORD_BITS{1'b1}});

  assign read_data   = r_data[w_idx][w_off];
  assign o_dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_wreq  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_miss) begin
          w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_REFILL;
        end
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_wreq  = 1'b1;
        mem_addr  = {r_tag[r_miss_idx], r_miss_idx, r_cnt, 2'b00};
        mem_wdata = r_data[r_miss_idx][r_cnt];
        if (mem_ok && w_last) begin
          w_next = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {r_miss_tag, r_miss_idx, r_cnt, 2'b00};
        if (mem_ok && w_last) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat counter, line status bits, captured miss address
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_miss_idx <= '0;
      r_miss_tag <= '0;
    end else begin
      if (w_miss) begin
        r_cnt      <= '0;
        r_miss_idx <= w_idx;
        r_miss_tag <= w_tag;
      end else if (w_beat) begin
        // Wraps back to zero after the last beat, ready for the next phase.
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          if (r_state == S_WB) begin
            r_dirty[r_miss_idx] <= 1'b0;
          end else begin
            r_valid[r_miss_idx] <= 1'b1;
            r_dirty[r_miss_idx] <= 1'b0;
          end
        end
      end
      // A write with no byte enables completes without touching the line.
      if (ok && wreq && (wbyte != 4'b0000)) begin
        r_dirty[w_idx] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data and tag arrays (contents are don't-care after reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_beat && (r_state == S_REFILL)) begin
      r_data[r_miss_idx][r_cnt] <= mem_rdata;
      if (w_last) begin
        r_tag[r_miss_idx] <= r_miss_tag;
      end
    end else if (ok && wreq) begin
      for (int b = 0; b < 4; b++) begin
        if (wbyte[b]) begin
          r_data[w_idx][w_off][8*b +: 8] <= write_data[8*b +: 8];
        end
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // r_missed marks that the request now in IDLE already took a miss, so its
  // eventual ok is not counted as a hit. It clears on that ok, or when req
  // drops after a flushed miss.
  logic r_missed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
      r_missed <= 1'b0;
    end else begin
      if (ok && !r_missed && (hit_cnt != 32'hFFFF_FFFF)) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (w_miss && (miss_cnt != 32'hFFFF_FFFF)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
      if (w_miss && (w_next == S_WB) && (wb_cnt != 32'hFFFF_FFFF)) begin
        wb_cnt <= wb_cnt + 32'd1;
      end
      if (w_miss) begin
        r_missed <= 1'b1;
      end else if ((r_state == S_IDLE) && (ok || !req)) begin
        r_missed <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// Testbench for dcache_direct: directed sequence plus randomized requests,
// checked against a transaction-level cache/memory model through queues.
module tb_dcache_direct;

  localparam int W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic         wreq;
  logic [W-1:0] addr;
  logic [W-1:0] write_data;
  logic [3:0]   wbyte;
  logic [W-1:0] read_data;
  logic         ok;
  logic         mem_req;
  logic         mem_wreq;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         mem_ok;
  logic [1:0]   dbg_state;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
  logic [31:0]  wb_cnt;
`endif

  always #5 clk = ~clk;

  dcache_direct dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .wreq       (wreq),
    .addr       (addr),
    .write_data (write_data),
    .wbyte      (wbyte),
    .read_data  (read_data),
    .ok         (ok),
    .mem_req    (mem_req),
    .mem_wreq   (mem_wreq),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ok     (mem_ok),
    .o_dbg_state(dbg_state)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .wb_cnt     (wb_cnt)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];        // expected read_data at each ok
  logic [64:0]  exp_beat_q[$];   // expected beats: {wreq, addr, wdata}
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: main memory image plus a 64-line x 4-word cache image.
  // Each request is resolved whole: eviction beats, refill beats, the word
  // returned and the merged result.
  // ---------------------------------------------------------------------------
  logic [W-1:0] mem_img [0:1023];
  bit           m_valid [64];
  bit           m_dirty [64];
  logic [21:0]  m_tag   [64];
  logic [W-1:0] m_data  [64][4];

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_req(input logic w, input logic [W-1:0] a, input logic [W-1:0] d,
                           input logic [3:0] be, output bit miss);
    int          idx;
    int          off;
    logic [21:0] tag;
    logic [W-1:0] ba;
    idx  = int'(a[9:4]);
    off  = int'(a[3:2]);
    tag  = a[31:10];
    miss = !(m_valid[idx] && (m_tag[idx] == tag));
    if (miss) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int k = 0; k < 4; k++) begin
          ba = {m_tag[idx], 6'(idx), 2'(k), 2'b00};
          exp_beat_q.push_back({1'b1, ba, m_data[idx][k]});
          mem_img[ba[11:2]] = m_data[idx][k];
        end
      end
      for (int k = 0; k < 4; k++) begin
        ba = {tag, 6'(idx), 2'(k), 2'b00};
        exp_beat_q.push_back({1'b0, ba, 32'h0});
        m_data[idx][k] = mem_img[ba[11:2]];
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
    end
    exp_q.push_back(m_data[idx][off]);
    if (w) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) m_data[idx][off][8*b +: 8] = d[8*b +: 8];
      end
      if (be != 4'b0000) m_dirty[idx] = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory responder / beat monitor (auto mode) and manual override
  // ---------------------------------------------------------------------------
  bit           mem_auto   = 1'b1;
  logic         auto_ok    = 1'b0;
  logic [W-1:0] auto_rdata = '0;
  logic         man_ok     = 1'b0;
  logic [W-1:0] man_rdata  = '0;
  int           last_ack_cyc = -10;

  assign mem_ok    = mem_auto ? auto_ok    : man_ok;
  assign mem_rdata = mem_auto ? auto_rdata : man_rdata;

  initial begin
    forever begin
      @(negedge clk);
      auto_ok = 1'b0;
      if (mem_auto && (rst === 1'b0) && (mem_req === 1'b1) && ($urandom_range(0, 3) != 0)) begin
        if (exp_beat_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got wreq=%0b addr=%0h expected no beat", mem_wreq, mem_addr);
        end else begin
          logic [64:0] e;
          e = exp_beat_q.pop_front();
          chk("mem_beat", {mem_wreq, mem_addr, (mem_wreq ? mem_wdata : 32'h0)}, e);
        end
        auto_rdata   = mem_img[mem_addr[11:2]];
        auto_ok      = 1'b1;
        last_ack_cyc = cyc;
      end
    end
  end

  // Response monitor: every ok pops one expected read word.
  always @(negedge clk) begin
    if (ok === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ok: got ok with data %0h expected no response", read_data);
      end else begin
        chk("read_data", 65'(read_data), 65'(exp_q.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic do_req(input logic w, input logic [W-1:0] a, input logic [W-1:0] d,
                        input logic [3:0] be);
    bit miss;
    int waited;
    model_req(w, a, d, be, miss);
    @(posedge clk); #1;
    req = 1'b1; wreq = w; addr = a; write_data = d; wbyte = be;
    waited = 0;
    forever begin
      @(negedge clk);
      if (ok === 1'b1) break;
      waited++;
      if (waited >= 300) break;
    end
    if (ok !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: got no ok for addr %0h expected ok within 300 cycles", a);
      exp_q.delete();
      exp_beat_q.delete();
    end else if (miss) begin
      chk("miss_latency", 65'(cyc), 65'(last_ack_cyc + 1));
    end else begin
      chk("hit_latency", 65'(waited), 65'(0));
    end
    @(posedge clk); #1;
    req = 1'b0; wreq = 1'b0; wbyte = 4'b0000;
  endtask

  function automatic logic [W-1:0] rand_addr();
    logic [5:0] idx;
    case ($urandom_range(0, 3))
      0:       idx = 6'h10;
      1:       idx = 6'h11;
      2:       idx = 6'h20;
      default: idx = 6'h3F;
    endcase
    return {22'($urandom_range(0, 3)), idx, 2'($urandom_range(0, 3)), 2'b00};
  endfunction

  task automatic rand_reqs(input int n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] be;
      be = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) be = 4'b0000;
      do_req(1'($urandom_range(0, 1)), rand_addr(), $urandom, be);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int waited;
    rst = 1'b1; req = 1'b0; wreq = 1'b0; addr = '0; write_data = '0; wbyte = '0;
    for (int i = 0; i < 1024; i++) mem_img[i] = $urandom;
    mem_img[10'h040] = 32'h11;
    mem_img[10'h041] = 32'h22;
    mem_img[10'h042] = 32'h33;
    mem_img[10'h043] = 32'h44;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ok",        65'(ok),        65'(0));
    chk("rst_mem_req",   65'(mem_req),   65'(0));
    chk("rst_mem_wreq",  65'(mem_wreq),  65'(0));
    chk("rst_mem_addr",  65'(mem_addr),  65'(0));
    chk("rst_mem_wdata", 65'(mem_wdata), 65'(0));
    chk("rst_state",     65'(dbg_state), 65'(0));
    @(negedge clk);
    rst = 1'b0;

    // Directed: cold fill, hits, partial write, wbyte==0 write, dirty eviction.
    do_req(1'b0, 32'h100, 32'h0, 4'b0000);
    do_req(1'b0, 32'h108, 32'h0, 4'b0000);
    do_req(1'b1, 32'h108, 32'hAABBCCDD, 4'b0011);
    do_req(1'b0, 32'h108, 32'h0, 4'b0000);
    do_req(1'b0, 32'h200, 32'h0, 4'b0000);
    do_req(1'b1, 32'h204, 32'hDEADBEEF, 4'b0000);
    do_req(1'b0, 32'h600, 32'h0, 4'b0000);
    do_req(1'b0, 32'h500, 32'h0, 4'b0000);
    do_req(1'b0, 32'h10C, 32'h0, 4'b0000);

    rand_reqs(300);

    // Reset in the middle of the second refill beat.
    mem_auto = 1'b0;
    man_ok   = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    req = 1'b1; wreq = 1'b0; addr = 32'h100; wbyte = 4'b0000;
    waited = 0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) break;
      waited++;
      if (waited >= 20) break;
    end
    chk("mr_beat0_req",  65'(mem_req),  65'(1));
    chk("mr_beat0_addr", 65'(mem_addr), 65'(32'h100));
    chk("mr_beat0_wreq", 65'(mem_wreq), 65'(0));
    man_rdata = mem_img[10'h040];
    man_ok    = 1'b1;
    @(negedge clk);
    man_ok = 1'b0;
    chk("mr_beat1_addr", 65'(mem_addr), 65'(32'h104));
    rst = 1'b1;
    #1;
    chk("mr_rst_mem_req", 65'(mem_req),   65'(0));
    chk("mr_rst_ok",      65'(ok),        65'(0));
    chk("mr_rst_state",   65'(dbg_state), 65'(0));
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    mem_auto = 1'b1;

    // After reset the line is gone: the read refills from 0x100 again.
    do_req(1'b0, 32'h100, 32'h0, 4'b0000);
    rand_reqs(40);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_empty",      65'(exp_q.size()),      65'(0));
    chk("exp_beat_q_empty", 65'(exp_beat_q.size()), 65'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
